sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator_if.sv | 32 +++
 rtl/sum_accumulator.sv | 125 ++++++++++++
 tb/tb_sum_accumulator.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_if
// Purpose  : Handshake bundle for sum_accumulator. The upstream sample channel
//            (i_valid / o_ready / i_data) and the downstream result channel
//            (o_valid / i_ready / o_data, plus o_count / o_ovf status) share
//            one interface. Signal names are seen from the accumulator.
// Modports : slave  - the accumulator itself
//            master - the environment driving samples and taking results
// Revision : 1.0 - initial release
// ============================================================================
interface sum_accumulator_if;
  logic               i_valid;   // upstream sample valid
  logic               o_ready;   // accumulator can take a sample
  logic signed [31:0] i_data;    // signed sample
  logic               o_valid;   // group result valid
  logic               i_ready;   // downstream takes the result
  logic signed [31:0] o_data;    // running sum in ACC, group sum in OUT
  logic [7:0]         o_count;   // samples accepted in the current group
  logic               o_ovf;     // sticky signed-overflow flag for the group

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count, o_ovf
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count, o_ovf
  );
endinterface
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Purpose  : Sums COUNT signed 32-bit samples per group and presents the group
//            total on a valid/ready result channel. Two-state machine:
//              ACC - o_ready=1, accepting samples, o_data = running sum
//              OUT - o_valid=1, result held stable until i_ready
//            Handshake outputs decode from state only.
// Params   : COUNT - samples per result, 1..255 (default 4)
// Macros   : SUM_ACCUMULATOR_SAT_EN - when defined, an overflowing add clamps
//            to the signed 32-bit extreme; otherwise the add wraps mod 2^32.
//            o_ovf behaves identically in both builds.
// Ports    : i_clk - clock, rising edge
//            i_rst - synchronous active-high reset
//            bus   - sum_accumulator_if.slave (sample in, result out)
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
  parameter int unsigned COUNT = 4
) (
  input wire                i_clk,
  input wire                i_rst,
  sum_accumulator_if.slave  bus
);

  localparam logic [7:0] C_COUNT = 8'(COUNT);
  localparam logic signed [31:0] C_MAX_POS = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] C_MAX_NEG = 32'sh8000_0000;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic signed [31:0] r_acc;
  logic signed [31:0] w_acc_next;
  logic [7:0]         r_count;
  logic [7:0]         w_count_next;
  logic               r_ovf;
  logic               w_ovf_next;

  logic               w_accept;
  logic               w_consume;
  logic [7:0]         w_count_inc;
  logic signed [31:0] w_sum_raw;
  logic signed [31:0] w_sum;
  logic               w_add_ovf;

  assign w_accept    = (r_state == ST_ACC) && bus.i_valid;
  assign w_consume   = (r_state == ST_OUT) && bus.i_ready;
  assign w_count_inc = r_count + 8'd1;

  // Two's complement add; overflow when both operands share a sign and the
  // raw result's sign differs from it.
  assign w_sum_raw = r_acc + bus.i_data;
  assign w_add_ovf = (r_acc[31] == bus.i_data[31]) && (w_sum_raw[31] != r_acc[31]);

`ifdef SUM_ACCUMULATOR_SAT_EN
  // Operand sign tells the overflow direction: both negative -> clamp low.
  assign w_sum = w_add_ovf ? (r_acc[31] ? C_MAX_NEG : C_MAX_POS) : w_sum_raw;
`else
  assign w_sum = w_sum_raw;
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;
    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          w_acc_next   = w_sum;
          w_count_next = w_count_inc;
          w_ovf_next   = r_ovf | w_add_ovf;
          if (w_count_inc == C_COUNT) begin
            w_state_next = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        // Consuming returns to ACC with a fresh group; no sample is taken on
        // this edge because o_ready is still low.
        if (w_consume) begin
          w_state_next = ST_ACC;
          w_acc_next   = '0;
          w_count_next = '0;
          w_ovf_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_ACC;
        w_acc_next   = '0;
        w_count_next = '0;
        w_ovf_next   = 1'b0;
      end
    endcase
  end

  // State register; reset wins over any simultaneous accept or consume.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign bus.o_ready = (r_state == ST_ACC);
  assign bus.o_valid = (r_state == ST_OUT);
  assign bus.o_data  = r_acc;
  assign bus.o_count = r_count;
  assign bus.o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Purpose  : Self-checking bench for sum_accumulator. Three instances cover
//            COUNT=4, COUNT=2 and COUNT=1. Expected group results are queued
//            when the last sample is driven and compared when o_valid shows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  sum_accumulator_if b4 ();
  sum_accumulator_if b2 ();
  sum_accumulator_if b1 ();

  sum_accumulator #(.COUNT(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(b4));
  sum_accumulator #(.COUNT(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(b2));
  sum_accumulator #(.COUNT(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));

  // Per-instance drive / observe arrays: index 0 -> COUNT=4, 1 -> 2, 2 -> 1
  logic               d_valid [3];
  logic signed [31:0] d_data  [3];
  logic               d_ready [3];
  logic               q_valid [3];
  logic               q_ready [3];
  logic signed [31:0] q_data  [3];
  logic [7:0]         q_count [3];
  logic               q_ovf   [3];

  assign b4.i_valid = d_valid[0];
  assign b4.i_data  = d_data[0];
  assign b4.i_ready = d_ready[0];
  assign b2.i_valid = d_valid[1];
  assign b2.i_data  = d_data[1];
  assign b2.i_ready = d_ready[1];
  assign b1.i_valid = d_valid[2];
  assign b1.i_data  = d_data[2];
  assign b1.i_ready = d_ready[2];

  assign q_valid[0] = b4.o_valid;
  assign q_ready[0] = b4.o_ready;
  assign q_data[0]  = b4.o_data;
  assign q_count[0] = b4.o_count;
  assign q_ovf[0]   = b4.o_ovf;
  assign q_valid[1] = b2.o_valid;
  assign q_ready[1] = b2.o_ready;
  assign q_data[1]  = b2.o_data;
  assign q_count[1] = b2.o_count;
  assign q_ovf[1]   = b2.o_ovf;
  assign q_valid[2] = b1.o_valid;
  assign q_ready[2] = b1.o_ready;
  assign q_data[2]  = b1.o_data;
  assign q_count[2] = b1.o_count;
  assign q_ovf[2]   = b1.o_ovf;

  int unsigned cnt_of [3] = '{4, 2, 1};

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;
  exp_t sb_q [$];

  typedef struct packed {
    logic [3:0][31:0] smp;
    logic [31:0]      exp_sum;
    logic             exp_ovf;
    logic [3:0]       hold;
  } vec_t;
  vec_t vt [6];

  // Reference model of the running group state
  logic signed [31:0] m_acc [3];
  int unsigned        m_cnt [3];
  logic               m_ovf [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model_add(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [32:0] wide;
    logic               ov;
    logic [31:0]        s;
    wide = {a[31], a} + {b[31], b};
    ov   = (wide[32] != wide[31]);
    s    = wide[31:0];
`ifdef SUM_ACCUMULATOR_SAT_EN
    if (ov) s = wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ov, s};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = '0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Called at a negedge; drives one sample and returns at the next negedge.
  task automatic push_sample(input int s, input logic signed [31:0] d);
    int          guard;
    logic [32:0] r;
    guard = 0;
    while (!q_ready[s] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!q_ready[s]) begin
      check("push_ready_timeout", 32'(q_ready[s]), 32'd1);
      return;
    end
    d_valid[s] = 1'b1;
    d_data[s]  = d;
    @(negedge clk);
    d_valid[s] = 1'b0;
    d_data[s]  = 32'hDEAD_BEEF;
    r = model_add(m_acc[s], d);
    m_acc[s] = r[31:0];
    m_ovf[s] = m_ovf[s] | r[32];
    m_cnt[s] = m_cnt[s] + 1;
    check("running_data", q_data[s], m_acc[s]);
    check("running_count", 32'(q_count[s]), m_cnt[s]);
    check("running_ovf", 32'(q_ovf[s]), 32'(m_ovf[s]));
    if (m_cnt[s] == cnt_of[s]) begin
      check("valid_latency", 32'(q_valid[s]), 32'd1);
      check("ready_low_in_out", 32'(q_ready[s]), 32'd0);
    end else begin
      check("ready_in_acc", 32'(q_ready[s]), 32'd1);
    end
  endtask

  // Waits for a result, compares with the scoreboard, holds i_ready low for
  // 'hold' cycles, then consumes. i_valid is kept high with junk data while
  // in OUT to show no sample is taken there or on the consume edge.
  task automatic pop_result(input int s, input int hold);
    int   guard;
    exp_t e;
    guard = 0;
    while (!q_valid[s] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!q_valid[s]) begin
      check("result_timeout", 32'(q_valid[s]), 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("result_data", q_data[s], e.sum);
    check("result_ovf", 32'(q_ovf[s]), 32'(e.ovf));
    check("result_count", 32'(q_count[s]), cnt_of[s]);
    d_valid[s] = 1'b1;
    d_data[s]  = 32'h0000_1234;
    for (int h = 0; h < hold; h++) begin
      d_ready[s] = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(q_valid[s]), 32'd1);
      check("hold_ready", 32'(q_ready[s]), 32'd0);
      check("hold_data", q_data[s], e.sum);
      check("hold_count", 32'(q_count[s]), cnt_of[s]);
      check("hold_ovf", 32'(q_ovf[s]), 32'(e.ovf));
    end
    d_ready[s] = 1'b1;
    @(negedge clk);
    d_ready[s] = 1'b0;
    d_valid[s] = 1'b0;
    check("after_consume_valid", 32'(q_valid[s]), 32'd0);
    check("after_consume_ready", 32'(q_ready[s]), 32'd1);
    check("after_consume_count", 32'(q_count[s]), 32'd0);
    check("after_consume_data", q_data[s], 32'd0);
    check("after_consume_ovf", 32'(q_ovf[s]), 32'd0);
    m_acc[s] = '0;
    m_cnt[s] = 0;
    m_ovf[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] nxt;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_valid[k] = 1'b0;
      d_data[k]  = 32'h5A5A_5A5A;
      d_ready[k] = 1'b0;
    end
    model_clear();

    // Vector table: samples, expected group sum/overflow, i_ready hold cycles
    vt[0] = '{smp: {32'd4, 32'd3, 32'd2, 32'd1}, exp_sum: 32'd10, exp_ovf: 1'b0, hold: 4'd0};
    vt[1] = '{smp: {-32'sd2, 32'd0, 32'd7, -32'sd5}, exp_sum: 32'd0, exp_ovf: 1'b0, hold: 4'd3};
    vt[2] = '{smp: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              exp_sum: 32'hFFFF_FFFC, exp_ovf: 1'b0, hold: 4'd1};
`ifdef SUM_ACCUMULATOR_SAT_EN
    vt[3] = '{smp: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF},
              exp_sum: 32'h7FFF_FFFD, exp_ovf: 1'b1, hold: 4'd0};
    vt[4] = '{smp: {32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000},
              exp_sum: 32'h8000_0001, exp_ovf: 1'b1, hold: 4'd2};
`else
    vt[3] = '{smp: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF},
              exp_sum: 32'h7FFF_FFFE, exp_ovf: 1'b1, hold: 4'd0};
    vt[4] = '{smp: {32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000},
              exp_sum: 32'h8000_0000, exp_ovf: 1'b1, hold: 4'd2};
`endif
    vt[5] = '{smp: {-32'sd75, 32'd25, -32'sd50, 32'd100}, exp_sum: 32'd0, exp_ovf: 1'b0, hold: 4'd0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of every instance
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", 32'(q_ready[k]), 32'd1);
      check("reset_valid", 32'(q_valid[k]), 32'd0);
      check("reset_count", 32'(q_count[k]), 32'd0);
      check("reset_data", q_data[k], 32'd0);
      check("reset_ovf", 32'(q_ovf[k]), 32'd0);
    end

    // Table-driven groups on COUNT=4
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) sb_q.push_back('{sum: vt[v].exp_sum, ovf: vt[v].exp_ovf});
        push_sample(0, vt[v].smp[i]);
        // Idle gap with junk data on odd vectors: must not be accepted
        if ((v % 2) == 1 && i == 1) begin
          d_data[0] = 32'h7777_7777;
          @(negedge clk);
          check("idle_count", 32'(q_count[0]), 32'd2);
        end
      end
      pop_result(0, int'(vt[v].hold));
    end

    // COUNT=2 overflow on the positive extreme
`ifdef SUM_ACCUMULATOR_SAT_EN
    sb_q.push_back('{sum: 32'h7FFF_FFFF, ovf: 1'b1});
`else
    sb_q.push_back('{sum: 32'h8000_0000, ovf: 1'b1});
`endif
    push_sample(1, 32'sh7FFF_FFFF);
    push_sample(1, 32'sd1);
    pop_result(1, 0);

    // Reset mid-group discards the partial sum
    push_sample(0, 32'sd5);
    push_sample(0, 32'sd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("midgroup_rst_count", 32'(q_count[0]), 32'd0);
    check("midgroup_rst_data", q_data[0], 32'd0);
    sb_q.push_back('{sum: 32'd4, ovf: 1'b0});
    for (int i = 0; i < 4; i++) push_sample(0, 32'sd1);
    pop_result(0, 0);

    // COUNT=1 with i_valid and i_ready held high: result every second cycle
    d_valid[2] = 1'b1;
    d_ready[2] = 1'b1;
    nxt = 32'sd3;
    d_data[2] = nxt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("c1_valid", 32'(q_valid[2]), ((i % 2) == 0) ? 32'd1 : 32'd0);
      if ((i % 2) == 0) begin
        check("c1_data", q_data[2], nxt);
        nxt = nxt + 32'sd1;
        d_data[2] = nxt;
      end else begin
        check("c1_ready", 32'(q_ready[2]), 32'd1);
        check("c1_count", 32'(q_count[2]), 32'd0);
      end
    end
    d_valid[2] = 1'b0;
    d_ready[2] = 1'b0;

    // Reset while a result is offered and i_ready=1: no consume, just clear
    push_sample(0, 32'sd9);
    push_sample(0, 32'sd9);
    push_sample(0, 32'sd9);
    push_sample(0, 32'sd9);
    check("pre_rst_valid", 32'(q_valid[0]), 32'd1);
    d_ready[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d_ready[0] = 1'b0;
    model_clear();
    check("rst_out_valid", 32'(q_valid[0]), 32'd0);
    check("rst_out_ready", 32'(q_ready[0]), 32'd1);
    check("rst_out_count", 32'(q_count[0]), 32'd0);
    check("rst_out_data", q_data[0], 32'd0);
    check("rst_out_ovf", 32'(q_ovf[0]), 32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
